// File: rtl/router_pkg.sv
// Shared types and header field layout for the 1x3 router write-side controller.
package router_pkg;

    typedef enum logic [2:0] {
        DECODE_ADDRESS,
        WAIT_TILL_EMPTY,
        LOAD_FIRST_DATA,
        WRITE_HEADER,
        LOAD_DATA,
        FIFO_FULL_STATE,
        CHECK_PARITY_ERROR
    } state_e;

    localparam logic [1:0] ADDR_INVALID = 2'b11;
    localparam int         NUM_PORTS    = 3;

    // Header byte = {len[5:0], addr[1:0]}
    localparam int LEN_MSB  = 7;
    localparam int LEN_LSB  = 2;
    localparam int ADDR_MSB = 1;
    localparam int ADDR_LSB = 0;

endpackage

// File: rtl/router_sft_timer.sv
// One channel's stall timer: pulses sft_rst_o when a non-empty FIFO goes unread for TIMEOUT cycles.
module router_sft_timer #(
    parameter int TIMEOUT = 30
) (
    input  logic clk,
    input  logic rst,
    input  logic vld_i,
    input  logic rd_i,
    output logic sft_rst_o
);

    localparam int            CW   = $clog2(TIMEOUT);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          sft_q, sft_d;

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        sft_d = 1'b0;
        if (!vld_i || rd_i) begin
            cnt_d = '0;
        end else if (cnt_q == LAST) begin
            cnt_d = '0;
            sft_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
            sft_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            sft_q <= sft_d;
        end
    end

    assign sft_rst_o = sft_q;

endmodule

// File: rtl/router_ctrl.sv
// Router write-side FSM: header decode, FIFO write sequencing, parity check and stall timers.
// Define ROUTER_LEN_CHECK_EN to also flag a payload count that disagrees with the header length.
module router_ctrl
    import router_pkg::*;
#(
    parameter int TIMEOUT    = 30,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  pkt_valid,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic [NUM_PORTS-1:0]  fifo_full,
    input  logic [NUM_PORTS-1:0]  fifo_empty,
    input  logic [NUM_PORTS-1:0]  read_en,
    output logic                  busy,
    output logic [NUM_PORTS-1:0]  wr_en,
    output logic [DATA_WIDTH-1:0] fifo_data,
    output logic                  lfd_state,
    output logic [NUM_PORTS-1:0]  sft_rst,
    output logic [NUM_PORTS-1:0]  vld_out,
    output logic                  err,
    output logic                  parity_done
);

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] hdr_q, hdr_d;
    logic [1:0]            addr_q, addr_d;
    logic [DATA_WIDTH-1:0] parity_q, parity_d;
    logic [DATA_WIDTH-1:0] rx_par_q, rx_par_d;
    logic                  err_q, err_d;
    logic                  pdone_q, pdone_d;
`ifdef ROUTER_LEN_CHECK_EN
    logic [5:0]            len_cnt_q, len_cnt_d;
`endif

    assign vld_out     = ~fifo_empty;
    assign err         = err_q;
    assign parity_done = pdone_q;

    always_comb begin
        state_d   = state_q;
        hdr_d     = hdr_q;
        addr_d    = addr_q;
        parity_d  = parity_q;
        rx_par_d  = rx_par_q;
        err_d     = err_q;
        pdone_d   = 1'b0;
        busy      = 1'b0;
        wr_en     = '0;
        fifo_data = '0;
        lfd_state = 1'b0;
`ifdef ROUTER_LEN_CHECK_EN
        len_cnt_d = len_cnt_q;
`endif
        case (state_q)
            DECODE_ADDRESS: begin
                // Address 3 has no FIFO: the header is consumed and dropped.
                if (pkt_valid && data_in[ADDR_MSB:ADDR_LSB] != ADDR_INVALID) begin
                    hdr_d    = data_in;
                    addr_d   = data_in[ADDR_MSB:ADDR_LSB];
                    parity_d = data_in;
                    err_d    = 1'b0;
`ifdef ROUTER_LEN_CHECK_EN
                    len_cnt_d = '0;
`endif
                    state_d  = fifo_empty[data_in[ADDR_MSB:ADDR_LSB]] ? LOAD_FIRST_DATA
                                                                     : WAIT_TILL_EMPTY;
                end
            end
            WAIT_TILL_EMPTY: begin
                busy = 1'b1;
                if (fifo_empty[addr_q]) state_d = LOAD_FIRST_DATA;
            end
            LOAD_FIRST_DATA: begin
                // FIFO registers lfd_state, so it must lead the header write by one cycle.
                busy      = 1'b1;
                lfd_state = 1'b1;
                state_d   = WRITE_HEADER;
            end
            WRITE_HEADER: begin
                busy          = 1'b1;
                wr_en[addr_q] = 1'b1;
                fifo_data     = hdr_q;
                state_d       = LOAD_DATA;
            end
            LOAD_DATA: begin
                busy = fifo_full[addr_q];
                if (fifo_full[addr_q]) begin
                    state_d = FIFO_FULL_STATE;
                end else begin
                    wr_en[addr_q] = 1'b1;
                    fifo_data     = data_in;
                    if (pkt_valid) begin
                        parity_d = parity_q ^ data_in;
`ifdef ROUTER_LEN_CHECK_EN
                        len_cnt_d = len_cnt_q + 6'd1;
`endif
                    end else begin
                        rx_par_d = data_in;
                        state_d  = CHECK_PARITY_ERROR;
                    end
                end
            end
            FIFO_FULL_STATE: begin
                busy = 1'b1;
                if (!fifo_full[addr_q]) state_d = LOAD_DATA;
            end
            CHECK_PARITY_ERROR: begin
                busy    = 1'b1;
                pdone_d = 1'b1;
`ifdef ROUTER_LEN_CHECK_EN
                err_d   = (parity_q != rx_par_q) || (len_cnt_q != hdr_q[LEN_MSB:LEN_LSB]);
`else
                err_d   = (parity_q != rx_par_q);
`endif
                state_d = DECODE_ADDRESS;
            end
            default: state_d = DECODE_ADDRESS;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= DECODE_ADDRESS;
            hdr_q    <= '0;
            addr_q   <= '0;
            parity_q <= '0;
            rx_par_q <= '0;
            err_q    <= 1'b0;
            pdone_q  <= 1'b0;
`ifdef ROUTER_LEN_CHECK_EN
            len_cnt_q <= '0;
`endif
        end else begin
            state_q  <= state_d;
            hdr_q    <= hdr_d;
            addr_q   <= addr_d;
            parity_q <= parity_d;
            rx_par_q <= rx_par_d;
            err_q    <= err_d;
            pdone_q  <= pdone_d;
`ifdef ROUTER_LEN_CHECK_EN
            len_cnt_q <= len_cnt_d;
`endif
        end
    end

    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_tmr
        router_sft_timer #(.TIMEOUT(TIMEOUT)) u_tmr (
            .clk       (clk),
            .rst       (rst),
            .vld_i     (vld_out[i]),
            .rd_i      (read_en[i]),
            .sft_rst_o (sft_rst[i])
        );
    end

endmodule

// File: tb/tb_router_ctrl.sv
// Directed bench for router_ctrl: packet sequencing, parity, stalls and timeout flush.
module tb_router_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       pkt_valid = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic [2:0] fifo_full = 3'b000;
    logic [2:0] fifo_empty = 3'b111;
    logic [2:0] read_en = 3'b000;
    logic       busy, lfd_state, err, parity_done;
    logic [2:0] wr_en, sft_rst, vld_out;
    logic [7:0] fifo_data;

    int vectors = 0;
    int miscompares = 0;
    int wcnt0 = 0, wcnt1 = 0, wcnt2 = 0;
    int cc_writes = 0;
    int max_ones = 0;
    int b0, b1, cc0;

    always #5 clk = ~clk;

    router_ctrl #(.TIMEOUT(30), .DATA_WIDTH(8)) dut (
        .clk(clk), .rst(rst), .pkt_valid(pkt_valid), .data_in(data_in),
        .fifo_full(fifo_full), .fifo_empty(fifo_empty), .read_en(read_en),
        .busy(busy), .wr_en(wr_en), .fifo_data(fifo_data), .lfd_state(lfd_state),
        .sft_rst(sft_rst), .vld_out(vld_out), .err(err), .parity_done(parity_done)
    );

    // Write monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst) begin
            if (wr_en[0]) wcnt0++;
            if (wr_en[1]) wcnt1++;
            if (wr_en[2]) wcnt2++;
            if (wr_en[0] && fifo_data == 8'hCC) cc_writes++;
            if ($countones(wr_en) > max_ones) max_ones = $countones(wr_en);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic nxt;
        @(posedge clk);
        #2;
    endtask

    // Advance one cycle, present a byte, and expect it to be written to port p.
    task automatic wr_byte(input int p, input logic [7:0] b, input logic v, input string tag);
        nxt;
        pkt_valid = v;
        data_in   = b;
        #1;
        chk({tag, " busy"}, busy, 0);
        chk({tag, " wr_en"}, wr_en, 3'b001 << p);
        chk({tag, " data"}, fifo_data, b);
    endtask

    initial begin
        #1 rst = 1'b0;
        #3;
        chk("rst busy", busy, 0);
        chk("rst wr_en", wr_en, 0);
        chk("rst fifo_data", fifo_data, 0);
        chk("rst lfd", lfd_state, 0);
        chk("rst err", err, 0);
        chk("rst pdone", parity_done, 0);
        chk("rst sft", sft_rst, 0);
        fifo_empty = 3'b010;
        #1 chk("rst vld_out", vld_out, 3'b101);
        fifo_empty = 3'b111;
        nxt;
        nxt;
        rst = 1'b1;

        // 1: good packet 0D 11 22 33 / parity 0D to port 1
        b1 = wcnt1;
        nxt;
        pkt_valid = 1'b1; data_in = 8'h0D;
        #1 chk("t1 idle busy", busy, 0);
        nxt;
        data_in = 8'h11;
        #1;
        chk("t1 lfd", lfd_state, 1);
        chk("t1 lfd busy", busy, 1);
        chk("t1 lfd wr_en", wr_en, 0);
        nxt;
        #1;
        chk("t1 hdr wr_en", wr_en, 3'b010);
        chk("t1 hdr data", fifo_data, 8'h0D);
        chk("t1 hdr lfd", lfd_state, 0);
        wr_byte(1, 8'h11, 1'b1, "t1 p0");
        wr_byte(1, 8'h22, 1'b1, "t1 p1");
        wr_byte(1, 8'h33, 1'b1, "t1 p2");
        wr_byte(1, 8'h0D, 1'b0, "t1 par");
        nxt;
        #1;
        chk("t1 chk busy", busy, 1);
        chk("t1 chk wr_en", wr_en, 0);
        chk("t1 chk pdone", parity_done, 0);
        nxt;
        #1;
        chk("t1 pdone", parity_done, 1);
        chk("t1 err", err, 0);
        nxt;
        #1;
        chk("t1 pdone drop", parity_done, 0);
        chk("t1 writes", wcnt1 - b1, 5);

        // 2: bad parity 0E
        pkt_valid = 1'b1; data_in = 8'h0D;
        nxt;
        data_in = 8'h11;
        nxt;
        wr_byte(1, 8'h11, 1'b1, "t2 p0");
        wr_byte(1, 8'h22, 1'b1, "t2 p1");
        wr_byte(1, 8'h33, 1'b1, "t2 p2");
        wr_byte(1, 8'h0E, 1'b0, "t2 par");
        nxt;
        nxt;
        #1;
        chk("t2 err", err, 1);
        chk("t2 pdone", parity_done, 1);
        nxt;
        #1 chk("t2 err hold", err, 1);

        // 3: invalid address header 03
        pkt_valid = 1'b1; data_in = 8'h03;
        #1 chk("t3 busy0", busy, 0);
        nxt;
        #1;
        chk("t3 busy1", busy, 0);
        chk("t3 wr_en", wr_en, 0);
        chk("t3 lfd", lfd_state, 0);
        chk("t3 err kept", err, 1);
        nxt;
        #1 chk("t3 busy2", busy, 0);
        pkt_valid = 1'b0;

        // 4: target FIFO 2 not empty, header 06
        b0 = wcnt2;
        fifo_empty = 3'b011;
        pkt_valid = 1'b1; data_in = 8'h06;
        nxt;
        data_in = 8'h55;
        #1;
        chk("t4 wait busy", busy, 1);
        chk("t4 wait wr_en", wr_en, 0);
        chk("t4 err cleared", err, 0);
        nxt;
        #1 chk("t4 wait busy2", busy, 1);
        fifo_empty = 3'b111;
        #1 chk("t4 release wr_en", wr_en, 0);
        nxt;
        #1;
        chk("t4 lfd", lfd_state, 1);
        chk("t4 lfd wr_en", wr_en, 0);
        nxt;
        #1;
        chk("t4 hdr wr_en", wr_en, 3'b100);
        chk("t4 hdr data", fifo_data, 8'h06);
        wr_byte(2, 8'h55, 1'b1, "t4 p0");
        wr_byte(2, 8'h53, 1'b0, "t4 par");
        nxt;
        nxt;
        #1;
        chk("t4 pdone", parity_done, 1);
        chk("t4 err", err, 0);
        chk("t4 writes", wcnt2 - b0, 3);

        // 5: FIFO 0 fills before third payload byte
        b0  = wcnt0;
        cc0 = cc_writes;
        pkt_valid = 1'b1; data_in = 8'h0C;
        nxt;
        data_in = 8'hAA;
        nxt;
        #1;
        chk("t5 hdr wr_en", wr_en, 3'b001);
        chk("t5 hdr data", fifo_data, 8'h0C);
        wr_byte(0, 8'hAA, 1'b1, "t5 p0");
        wr_byte(0, 8'hBB, 1'b1, "t5 p1");
        nxt;
        data_in = 8'hCC; fifo_full = 3'b001;
        #1;
        chk("t5 full busy", busy, 1);
        chk("t5 full wr_en", wr_en, 0);
        nxt;
        #1;
        chk("t5 hold busy", busy, 1);
        chk("t5 hold wr_en", wr_en, 0);
        fifo_full = 3'b000;
        #1;
        chk("t5 release busy", busy, 1);
        chk("t5 release wr_en", wr_en, 0);
        wr_byte(0, 8'hCC, 1'b1, "t5 p2");
        wr_byte(0, 8'hD1, 1'b0, "t5 par");
        nxt;
        nxt;
        #1;
        chk("t5 pdone", parity_done, 1);
        chk("t5 err", err, 0);
        chk("t5 writes", wcnt0 - b0, 5);
        chk("t5 no dup", cc_writes - cc0, 1);

        // 6a: FIFO 0 never read -> flush on the 30th cycle
        fifo_empty = 3'b110;
        #1 chk("t6 vld_out", vld_out, 3'b001);
        for (int i = 1; i <= 30; i++) begin
            nxt;
            #1 chk($sformatf("t6 sft c%0d", i), sft_rst, (i == 30) ? 3'b001 : 3'b000);
        end
        nxt;
        #1 chk("t6 sft drop", sft_rst, 0);
        fifo_empty = 3'b111;
        nxt;
        nxt;

        // 6b: read at cycle 29 prevents the flush
        fifo_empty = 3'b110;
        for (int i = 1; i <= 40; i++) begin
            read_en = (i == 29) ? 3'b001 : 3'b000;
            nxt;
            #1 chk($sformatf("t6b sft c%0d", i), sft_rst, 0);
        end
        read_en = 3'b000;
        fifo_empty = 3'b111;

        chk("onehot wr_en", (max_ones <= 1), 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
